uart_param: RTL and testbench
=============================

UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide), legal range >= 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per TX frame, legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, RX FIFO entries, power of two, 2..64.
REQ-006 SHALL have ports:
  clk  in  1  single clock, all logic rising-edge
  rst_n  in  1  asynchronous active-low reset
  tx_valid  in  1  TX byte offered
  tx_data  in  DATA_BITS  TX payload, LSB sent first
  tx_ready  out  1  transmitter idle, accepts byte
  tx  out  1  serial line out, idle high
  rx  in  1  serial line in, asynchronous
  parity_odd  in  1  1 = odd parity, 0 = even; ignored unless UART_PARITY_EN
  rx_data  out  DATA_BITS  head of RX FIFO
  rx_valid  out  1  RX FIFO not empty
  rx_ack  in  1  pop RX FIFO head when rx_valid
  rx_frame_err  out  1  one-cycle pulse, bad stop bit
  rx_parity_err  out  1  one-cycle pulse, parity mismatch
  rx_overrun  out  1  one-cycle pulse, good frame dropped, FIFO full

Function
REQ-007 TX SHALL accept a byte on a cycle with tx_valid && tx_ready; tx_ready SHALL be 0 from the next cycle.
REQ-008 TX FSM SHALL use states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; tx SHALL go low the cycle after acceptance.
REQ-009 Each TX bit SHALL be held exactly CLKS_PER_BIT cycles; STOP lasts STOP_BITS*CLKS_PER_BIT cycles at tx=1.
REQ-010 tx_ready SHALL return to 1 on the cycle after the final stop-bit period ends; back-to-back bytes SHALL give no extra idle gap.
REQ-011 tx_data SHALL be captured at acceptance; later changes SHALL not affect the frame in flight.
REQ-012 rx SHALL pass through a 2-flop synchroniser; all RX decisions SHALL use its output.
REQ-013 RX FSM SHALL use states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
REQ-014 In IDLE, a synchronised low SHALL enter START; line sampled at CLKS_PER_BIT/2; if high, return to IDLE (glitch rejected, no error).
REQ-015 Data, parity and stop bits SHALL each be sampled once, CLKS_PER_BIT cycles after the previous sample.
REQ-016 RX SHALL check one stop bit regardless of STOP_BITS.
REQ-017 Stop sample 0 SHALL discard the frame, pulse rx_frame_err, and hold RX in IDLE until the line is sampled high.
REQ-018 A good frame SHALL be written into the FIFO on the cycle after the stop sample; rx_valid SHALL rise the following cycle if the FIFO was empty.
REQ-019 rx_data SHALL be the oldest entry and remain stable while rx_valid && !rx_ack.
REQ-020 rx_ack with rx_valid=0 SHALL be ignored.
REQ-021 A good frame arriving with the FIFO full SHALL be dropped with rx_overrun pulsed, unless rx_ack pops in the same cycle; then push and pop both occur.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a full/empty distinction allowing all FIFO_DEPTH entries to be used.
REQ-023 Error pulses SHALL be mutually exclusive per frame, priority frame > parity > overrun.

Reset
REQ-024 rst_n low SHALL asynchronously force: tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error pulses 0, FIFO empty, both FSMs IDLE, counters 0, synchroniser flops 1.
REQ-025 Reset mid-frame SHALL abort TX (tx=1 immediately) and discard the partial RX frame; no error pulse on release.

Configuration
REQ-026 With macro UART_PARITY_EN defined, TX SHALL insert one parity bit after data (even: XOR of data; odd: inverted); RX SHALL check it, discard on mismatch and pulse rx_parity_err.
REQ-027 Without UART_PARITY_EN, frames SHALL carry no parity bit, parity_odd SHALL be unused, and rx_parity_err SHALL be tied 0.

Verification (CLK_FREQ=1600000, BAUD_RATE=100000 => 16 clks/bit, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4)
REQ-028 Send tx_data=0xA5 -> tx low 1 cycle after accept; bits 1,0,1,0,0,1,0,1 each 16 cycles; stop; tx_ready high 160 cycles after accept.
REQ-029 Loop tx to rx, send 0x3C -> rx_valid with rx_data=0x3C, no error pulse; rx_ack -> rx_valid=0 next cycle.
REQ-030 Drive 5 frames 0x01..0x05, no rx_ack -> FIFO holds 0x01..0x04, rx_overrun pulses once on 0x05.
REQ-031 Frame 0x55 with stop bit 0 -> rx_frame_err 1-cycle pulse, FIFO unchanged; 4-cycle low glitch on idle line -> no activity.
REQ-032 UART_PARITY_EN, parity_odd=0, 0x07 -> TX parity bit 1; RX frame with flipped parity -> rx_parity_err pulse, frame dropped.
REQ-033 Assert rst_n=0 mid-TX data bit 3 -> tx=1 and tx_ready=1 same cycle; next send completes correctly.

Source files
------------

// File: rtl/uart_param_if.sv
// Bundles the UART byte-side handshakes and the two serial pins into one port.
// Latency: none; this file holds signals only.
// Backpressure: tx_valid/tx_ready for TX, rx_valid/rx_ack for RX.
interface uart_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx;
    logic                 rx;
    logic                 parity_odd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    // UART side: consumes the TX byte and RX pin, produces everything else
    modport slave (
        input  tx_valid, tx_data, rx, parity_odd, rx_ack,
        output tx_ready, tx, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );

    // User side: mirror image of the UART
    modport master (
        output tx_valid, tx_data, rx, parity_odd, rx_ack,
        input  tx_ready, tx, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );
endinterface

// File: rtl/uart_param.sv
// Parameterised UART: TX serialiser, RX deserialiser with 2-flop sync, RX FIFO.
// Latency: tx low 1 cycle after accept; RX byte pushed 1 cycle after stop sample.
// Backpressure: tx_ready low while a frame is in flight; full FIFO drops with rx_overrun.
// Optional parity bit enabled by defining macro UART_PARITY_EN.
module uart_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_param_if.slave  bus
);
    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(STOP_BITS * CPB + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * CPB - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    logic par_sel;
    assign par_sel = bus.parity_odd;
`else
    localparam bit PAR_EN = 1'b0;
    logic par_sel;
    assign par_sel = 1'b0;
`endif

    // ---------------- TX ----------------
    state_t               tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_ready_q, tx_ready_d;

    // TX next state: tx_q always carries the level of the bit currently on the line
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        case (tx_state_q)
            S_IDLE: begin
                if (bus.tx_valid && tx_ready_q) begin
                    tx_shift_d = bus.tx_data;
                    tx_par_d   = (^bus.tx_data) ^ par_sel;
                    tx_cnt_d   = '0;
                    tx_state_d = S_START;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = PAR_EN ? S_PARITY : S_STOP;
                        tx_d       = PAR_EN ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            S_PARITY: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                // The whole stop period (one or two bits) is timed as one interval
                if (tx_cnt_q == STOP_END) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                    tx_ready_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_d       = 1'b1;
                tx_ready_d = 1'b1;
            end
        endcase
    end

    // TX registers; reset aborts any frame and drives the line idle at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = tx_ready_q;

    // ---------------- RX ----------------
    logic                 rx_s1_q, rx_s2_q;
    logic                 rx_in;
    state_t               rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_pbad_q, rx_pbad_d;
    logic                 rx_hold_q, rx_hold_d;
    logic                 rx_push_q, rx_push_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_perr_q, rx_perr_d;

    assign rx_in = rx_s2_q;

    // Synchroniser for the asynchronous serial input; idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= bus.rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    // RX next state: mid-bit sampling; hold flag keeps IDLE after a framing error until the line is high
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_pbad_d  = rx_pbad_q;
        rx_hold_d  = rx_hold_q;
        rx_push_d  = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_perr_d  = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_hold_q) begin
                    if (rx_in) rx_hold_d = 1'b0;
                end else if (!rx_in) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d  = '0;
                    rx_bit_d  = '0;
                    rx_pbad_d = 1'b0;
                    // A line that is high again at mid-start was a glitch
                    rx_state_d = rx_in ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            S_PARITY: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_pbad_d  = rx_in != ((^rx_shift_q) ^ par_sel);
                    rx_state_d = S_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                // Only the first stop bit is checked; errors are exclusive, framing first
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    if (!rx_in) begin
                        rx_ferr_d = 1'b1;
                        rx_hold_d = 1'b1;
                    end else if (rx_pbad_q) begin
                        rx_perr_d = 1'b1;
                    end else begin
                        rx_push_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX registers; reset discards any partial frame without flagging it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_pbad_q  <= 1'b0;
            rx_hold_q  <= 1'b0;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_pbad_q  <= rx_pbad_d;
            rx_hold_q  <= rx_hold_d;
            rx_push_q  <= rx_push_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          fifo_cnt_q, fifo_cnt_d;
    logic                 ovr_q, ovr_d;
    logic                 pop, push, full;

    // FIFO control: a pop in the same cycle frees the slot for a push into a full FIFO
    always_comb begin
        pop        = bus.rx_ack && (fifo_cnt_q != '0);
        full       = fifo_cnt_q == FULL_CNT;
        push       = rx_push_q && (!full || pop);
        ovr_d      = rx_push_q && full && !pop;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = rx_shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            ovr_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.rx_data       = mem_q[rd_ptr_q];
    assign bus.rx_valid      = fifo_cnt_q != '0;
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param at 16 clocks per bit, 8N1, 4-entry FIFO.
// Drives RX frames directly or loops tx back to rx.
// Parity sequences are compiled in when UART_PARITY_EN is defined.
module tb_uart_param;
    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loop = 1'b0;
    logic rx_drv = 1'b1;
    always #5 clk = ~clk;

    uart_param_if #(.DATA_BITS(8)) bus();
    assign bus.rx = loop ? bus.tx : rx_drv;

    uart_param #(
        .CLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    int n_pass = 0, n_total = 0;
    int ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;

    always @(negedge clk) begin
        if (bus.rx_frame_err)  ferr_cnt++;
        if (bus.rx_parity_err) perr_cnt++;
        if (bus.rx_overrun)    ovr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        rx_drv = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (CPB) tick();
        end
        if (PB == 1) begin
            rx_drv = (^d) ^ bus.parity_odd ^ par_flip;
            repeat (CPB) tick();
        end
        rx_drv = stop;
        repeat (CPB) tick();
        rx_drv = 1'b1;
        repeat (6) tick();
    endtask

    task automatic pop_one();
        bus.rx_ack = 1'b1;
        tick();
        bus.rx_ack = 1'b0;
    endtask

    // Send one byte and check every bit boundary of the waveform plus tx_ready timing
    task automatic check_tx_frame(input logic [7:0] d);
        logic bits [11];
        int   nb;
        nb = 10 + PB;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (PB == 1) bits[9] = (^d) ^ bus.parity_odd;
        bits[nb-1] = 1'b1;
        chk("tx_ready_before", bus.tx_ready, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = ~d;
        chk("tx_ready_drop", bus.tx_ready, 0);
        for (int c = 0; c < CPB * nb; c++) begin
            if (c % CPB == 0 || c % CPB == CPB - 1)
                chk($sformatf("tx_%02h_bit%0d_c%0d", d, c / CPB, c), bus.tx, bits[c / CPB]);
            if (c == CPB * nb - 1) chk("tx_ready_last_stop", bus.tx_ready, 0);
            tick();
        end
        chk("tx_ready_return", bus.tx_ready, 1);
        chk("tx_idle_after", bus.tx, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        int         exp_ferr;
    } rxv_t;

    initial begin
        rxv_t vt [5];
        int   f0, o0, p0;
        bit   ok;

        vt[0] = '{8'h3C, 1'b1, 1'b1, 0};
        vt[1] = '{8'hFF, 1'b1, 1'b1, 0};
        vt[2] = '{8'h00, 1'b1, 1'b1, 0};
        vt[3] = '{8'h55, 1'b0, 1'b0, 1};
        vt[4] = '{8'h81, 1'b1, 1'b1, 0};

        bus.tx_valid   = 1'b0;
        bus.tx_data    = 8'h00;
        bus.rx_ack     = 1'b0;
        bus.parity_odd = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_tx", bus.tx, 1);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_errs", {bus.rx_frame_err, bus.rx_parity_err, bus.rx_overrun}, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // TX waveform of 0xA5
        check_tx_frame(8'hA5);

        // Short glitch on idle line is ignored
        f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
        rx_drv = 1'b0;
        repeat (4) tick();
        rx_drv = 1'b1;
        repeat (30) tick();
        chk("glitch_valid", bus.rx_valid, 0);
        chk("glitch_errs", ferr_cnt - f0 + ovr_cnt - o0 + perr_cnt - p0, 0);

        // Table of directly driven RX frames
        for (int v = 0; v < 5; v++) begin
            f0 = ferr_cnt; o0 = ovr_cnt;
            drive_frame(vt[v].data, vt[v].stop, 1'b0);
            chk($sformatf("vec%0d_valid", v), bus.rx_valid, vt[v].exp_valid);
            if (vt[v].exp_valid) chk($sformatf("vec%0d_data", v), bus.rx_data, vt[v].data);
            chk($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vt[v].exp_ferr);
            chk($sformatf("vec%0d_ovr", v), ovr_cnt - o0, 0);
            if (bus.rx_valid) begin
                pop_one();
                chk($sformatf("vec%0d_popped", v), bus.rx_valid, 0);
            end
        end

        // Loopback 0x3C
        f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
        loop = 1'b1;
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            if (bus.rx_valid) ok = 1'b1;
            else tick();
        end
        chk("loop_valid_seen", ok, 1);
        chk("loop_data", bus.rx_data, 8'h3C);
        chk("loop_errs", ferr_cnt - f0 + ovr_cnt - o0 + perr_cnt - p0, 0);
        pop_one();
        chk("loop_ack_clears", bus.rx_valid, 0);
        repeat (10) tick();
        loop = 1'b0;
        repeat (4) tick();

        // Five frames without ack: four stored, fifth overruns
        f0 = ferr_cnt; o0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) drive_frame(8'(i), 1'b1, 1'b0);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        chk("ovr_no_ferr", ferr_cnt - f0, 0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("fifo%0d_valid", i), bus.rx_valid, 1);
            chk($sformatf("fifo%0d_data", i), bus.rx_data, i);
            pop_one();
        end
        chk("fifo_drained", bus.rx_valid, 0);

        // Ack while empty must not disturb the FIFO
        pop_one();
        chk("empty_ack_valid", bus.rx_valid, 0);
        drive_frame(8'h66, 1'b1, 1'b0);
        chk("after_empty_ack_valid", bus.rx_valid, 1);
        chk("after_empty_ack_data", bus.rx_data, 8'h66);
        pop_one();
        chk("after_empty_ack_drained", bus.rx_valid, 0);

`ifdef UART_PARITY_EN
        check_tx_frame(8'h07);
        p0 = perr_cnt; f0 = ferr_cnt;
        drive_frame(8'h07, 1'b1, 1'b1);
        chk("par_err_pulse", perr_cnt - p0, 1);
        chk("par_no_ferr", ferr_cnt - f0, 0);
        chk("par_dropped", bus.rx_valid, 0);
`else
        chk("no_parity_errs", perr_cnt, 0);
`endif

        // Reset during TX data bit 3, then a clean frame
        f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        repeat (CPB * 4 + 5) tick();
        chk("pre_rst_busy", bus.tx_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", bus.tx, 1);
        chk("rst_mid_tx_ready", bus.tx_ready, 1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_no_err", ferr_cnt - f0 + ovr_cnt - o0 + perr_cnt - p0, 0);
        check_tx_frame(8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
